neuron_mac: RTL and testbench



---
 rtl/neuron_mac.sv | 159 +++++++++++++++
 tb/tb_neuron_mac.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac.sv
// neuron_mac: per-neuron multiply-accumulate stage fed by weight_memory.
//
// Each valid input activation issues a weight read at a wrapping address,
// is multiplied by the returned weight one cycle later, and the products are
// accumulated with saturation. After numWeight products the bias is added and
// a saturated dataWidth neuron sum is emitted as a one-cycle pulse.
//
// Ports:
//   clk        in   clock, all state on rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   in_data valid this cycle
//   in_data    in   signed input activation (Q(dataWidth-fracBits).fracBits)
//   bias       in   signed bias, stable for the duration of a vector
//   wmem_ren   out  weight read enable (combinational copy of in_valid)
//   wmem_radd  out  weight read address (registered read counter)
//   wmem_rdata in   weight returned one cycle after wmem_ren
//   out_valid  out  one-cycle pulse, neuron sum valid
//   out_data   out  signed saturated neuron sum, held until next pulse
module neuron_mac #(
  parameter int unsigned numWeight    = 3,
  parameter int unsigned addressWidth = 10,
  parameter int unsigned dataWidth    = 16,
  parameter int unsigned fracBits     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [dataWidth-1:0]    in_data,
  input  logic [dataWidth-1:0]    bias,
  output logic                    wmem_ren,
  output logic [addressWidth-1:0] wmem_radd,
  input  logic [dataWidth-1:0]    wmem_rdata,
  output logic                    out_valid,
  output logic [dataWidth-1:0]    out_data
);

  localparam int unsigned AccW = 2 * dataWidth;
  localparam int unsigned CntW = $clog2(numWeight + 1);

  localparam logic [AccW-1:0]      AccMax = {1'b0, {(AccW - 1){1'b1}}};
  localparam logic [AccW-1:0]      AccMin = {1'b1, {(AccW - 1){1'b0}}};
  localparam logic [dataWidth-1:0] OutMax = {1'b0, {(dataWidth - 1){1'b1}}};
  localparam logic [dataWidth-1:0] OutMin = {1'b1, {(dataWidth - 1){1'b0}}};

  logic [addressWidth-1:0] rd_cnt_q, rd_cnt_d;
  logic [dataWidth-1:0]    x_q;
  logic                    v1_q, v2_q;
  logic [AccW-1:0]         prod_q, acc_q, acc_d;
  logic [CntW-1:0]         acc_cnt_q, acc_cnt_d;
  logic                    fin_q, fin_d;
  logic                    out_valid_q, out_valid_d;
  logic [dataWidth-1:0]    out_data_q, out_data_d;

  logic signed [AccW-1:0]  prod_mul;
  logic [AccW-1:0]         bias_sh;
  logic signed [AccW-1:0]  sum_sat;
  logic signed [AccW-1:0]  sum_shift;
  logic [dataWidth-1:0]    out_sat;

  // Two's-complement add that clamps when both operands share a sign the
  // result does not.
  function automatic logic [AccW-1:0] sat_add(input logic [AccW-1:0] a,
                                              input logic [AccW-1:0] b);
    logic [AccW-1:0] s;
    s = a + b;
    if ((a[AccW-1] == b[AccW-1]) && (s[AccW-1] != a[AccW-1])) begin
      s = a[AccW-1] ? AccMin : AccMax;
    end
    return s;
  endfunction

  assign wmem_ren  = in_valid;
  assign wmem_radd = rd_cnt_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    if (in_valid) begin
      rd_cnt_d = (rd_cnt_q == addressWidth'(numWeight - 1)) ? '0
                                                             : rd_cnt_q + addressWidth'(1);
    end
  end

  // Full-width signed product: 2*fracBits fractional bits.
  always_comb begin
    prod_mul = $signed(x_q) * $signed(wmem_rdata);
  end

  // Bias aligned to the accumulator's 2*fracBits binary point.
  always_comb begin
    bias_sh   = {{(AccW - dataWidth){bias[dataWidth-1]}}, bias} << fracBits;
    sum_sat   = sat_add(acc_q, bias_sh);
    sum_shift = sum_sat >>> fracBits;
    // Fits in dataWidth only if all bits from the output sign bit up agree.
    if ((&sum_shift[AccW-1:dataWidth-1]) || !(|sum_shift[AccW-1:dataWidth-1])) begin
      out_sat = sum_shift[dataWidth-1:0];
    end else begin
      out_sat = sum_shift[AccW-1] ? OutMin : OutMax;
    end
  end

  always_comb begin
    acc_d       = acc_q;
    acc_cnt_d   = acc_cnt_q;
    fin_d       = fin_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    if (fin_q) begin
      out_valid_d = 1'b1;
      out_data_d  = out_sat;
      // A product arriving on the finishing edge starts the next vector.
      if (v2_q) begin
        acc_d     = prod_q;
        acc_cnt_d = CntW'(1);
      end else begin
        acc_d     = '0;
        acc_cnt_d = '0;
      end
      fin_d = v2_q && (numWeight == 32'd1);
    end else if (v2_q) begin
      acc_d     = sat_add(acc_q, prod_q);
      acc_cnt_d = acc_cnt_q + CntW'(1);
      fin_d     = (acc_cnt_d == CntW'(numWeight));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q    <= '0;
      x_q         <= '0;
      v1_q        <= 1'b0;
      prod_q      <= '0;
      v2_q        <= 1'b0;
      acc_q       <= '0;
      acc_cnt_q   <= '0;
      fin_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      rd_cnt_q    <= rd_cnt_d;
      v1_q        <= in_valid;
      if (in_valid) begin
        x_q <= in_data;
      end
      v2_q        <= v1_q;
      // Read data is only meaningful the cycle after a read was issued.
      if (v1_q) begin
        prod_q <= prod_mul;
      end
      acc_q       <= acc_d;
      acc_cnt_q   <= acc_cnt_d;
      fin_q       <= fin_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Bench for neuron_mac: directed scenarios plus randomized vectors, checked
// every cycle against an arithmetic model of the neuron sum.
module tb_neuron_mac;

  localparam int NW = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic [15:0] bias = '0;
  logic        wmem_ren;
  logic [9:0]  wmem_radd;
  logic [15:0] wmem_rdata = '0;
  logic        out_valid;
  logic [15:0] out_data;

  logic [15:0] mem [0:1023];

  int checks = 0;
  int failures = 0;

  neuron_mac #(
    .numWeight   (3),
    .addressWidth(10),
    .dataWidth   (16),
    .fracBits    (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .bias      (bias),
    .wmem_ren  (wmem_ren),
    .wmem_radd (wmem_radd),
    .wmem_rdata(wmem_rdata),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  // Weight memory: registered read, data one cycle after the enable.
  always @(posedge clk) begin
    if (wmem_ren) wmem_rdata <= mem[wmem_radd];
  end

  // ---------------- reference model ----------------
  typedef struct { int fin_cyc; longint acc; } pend_t;
  typedef struct { int due; logic [15:0] val; } exp_t;

  int          cyc = 0;
  int          m_rd = 0;
  int          m_n = 0;
  longint      m_acc = 0;
  pend_t       pend[$];
  exp_t        outq[$];
  logic [15:0] held = '0;
  int          pulses = 0;
  logic [15:0] last_out = '0;
  logic [15:0] pulse_log[$];
  int          pulse_cyc[$];

  function automatic longint sat32(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  function automatic logic [15:0] sat16(input longint v);
    longint c;
    c = v;
    if (c > 32767) c = 32767;
    if (c < -32768) c = -32768;
    return c[15:0];
  endfunction

  // Called at each rising edge with the inputs of the cycle that is ending.
  task automatic model_update();
    longint p, s;
    exp_t e;
    if (!rst_n) begin
      m_rd = 0; m_n = 0; m_acc = 0;
      pend.delete();
      outq.delete();
    end else begin
      // Bias is taken three cycles after the last input of a vector.
      if (pend.size() > 0 && pend[0].fin_cyc == cyc) begin
        s = sat32(pend[0].acc + longint'($signed(bias)) * 256);
        e.due = cyc + 1;
        e.val = sat16(s >>> 8);
        outq.push_back(e);
        pend.delete(0);
      end
      if (in_valid) begin
        p = longint'($signed(in_data)) * longint'($signed(mem[m_rd]));
        m_acc = sat32(m_acc + p);
        m_n++;
        m_rd = (m_rd + 1) % NW;
        if (m_n == NW) begin
          pend.push_back('{fin_cyc: cyc + 3, acc: m_acc});
          m_acc = 0;
          m_n = 0;
        end
      end
    end
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic compare();
    if (!rst_n) begin
      held = '0;
      return;
    end
    chk("wmem_ren", 32'(wmem_ren), 32'(in_valid));
    chk("wmem_radd", 32'(wmem_radd), m_rd);
    if (outq.size() > 0 && outq[0].due == cyc) begin
      chk("out_valid pulse", 32'(out_valid), 1);
      chk("out_data", 32'(out_data), 32'(outq[0].val));
      held = outq[0].val;
      pulses++;
      last_out = out_data;
      pulse_log.push_back(out_data);
      pulse_cyc.push_back(cyc);
      outq.delete(0);
    end else begin
      chk("out_valid idle", 32'(out_valid), 0);
      chk("out_data hold", 32'(out_data), 32'(held));
    end
  endtask

  // Drive one cycle of input, advance, then check that cycle's outputs.
  task automatic step(input logic v, input logic [15:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    model_update();
    @(negedge clk);
    #1;
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'($urandom));
  endtask

  task automatic drain();
    idle(8);
    chk("model drained", outq.size() + pend.size(), 0);
  endtask

  task automatic set_w(input logic [15:0] w);
    for (int a = 0; a < NW; a++) mem[a] = w;
  endtask

  // Sends n inputs back to back, pinning the read address sequence.
  task automatic send_run(input int n, input logic [15:0] d, output int t_last);
    for (int i = 0; i < n; i++) begin
      chk("radd seq", 32'(wmem_radd), i % NW);
      t_last = cyc;
      step(1'b1, d);
    end
  endtask

  function automatic logic [15:0] rnd16(input int mode);
    logic [15:0] pick [4];
    pick[0] = 16'h7FFF; pick[1] = 16'h8000; pick[2] = 16'h0001; pick[3] = 16'hFFFF;
    case (mode)
      1: return 16'($signed($urandom_range(0, 1023)) - 512);
      2: return pick[$urandom_range(0, 3)];
      default: return 16'($urandom);
    endcase
  endfunction

  int t3, t6, tl;

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = '0;
    set_w(16'h0100);

    // Reset state, with wmem_ren following in_valid while in reset.
    step(1'b1, 16'h1234);
    step(1'b1, 16'h1234);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset out_data", 32'(out_data), 0);
    chk("reset wmem_radd", 32'(wmem_radd), 0);
    chk("reset wmem_ren", 32'(wmem_ren), 1);
    rst_n = 1'b1;
    idle(2);

    // Basic: 3 x 2.0 * 1.0 + 0.5 = 6.5.
    bias = 16'h0080;
    pulse_log.delete(); pulse_cyc.delete();
    send_run(3, 16'h0200, tl);
    drain();
    chk("basic count", pulse_log.size(), 1);
    chk("basic value", 32'(last_out), 32'h0680);
    if (pulse_cyc.size() > 0) chk("basic latency", pulse_cyc[0] - tl, 4);

    // Positive saturation.
    set_w(16'h7FFF);
    bias = 16'h7FFF;
    send_run(3, 16'h7FFF, tl);
    drain();
    chk("pos sat", 32'(last_out), 32'h7FFF);

    // Negative saturation.
    set_w(16'h8000);
    bias = 16'h0000;
    send_run(3, 16'h7FFF, tl);
    drain();
    chk("neg sat", 32'(last_out), 32'h8000);

    // Back-to-back vectors; bias changes after the first sum is formed.
    set_w(16'h0100);
    bias = 16'h0080;
    pulse_log.delete(); pulse_cyc.delete();
    send_run(3, 16'h0200, t3);
    for (int i = 0; i < 3; i++) begin
      t6 = cyc;
      step(1'b1, 16'hFF00);
    end
    bias = 16'h0000;
    drain();
    chk("b2b count", pulse_log.size(), 2);
    chk("b2b first", 32'(pulse_log[0]), 32'h0680);
    chk("b2b second", 32'(pulse_log[1]), 32'hFD00);
    chk("b2b lat1", pulse_cyc[0] - t3, 4);
    chk("b2b lat2", pulse_cyc[1] - t6, 4);

    // Gapped inputs.
    bias = 16'h0080;
    pulse_log.delete(); pulse_cyc.delete();
    for (int i = 0; i < 3; i++) begin
      tl = cyc;
      step(1'b1, 16'h0200);
      if (i < 2) idle(2);
    end
    drain();
    chk("gap count", pulse_log.size(), 1);
    chk("gap value", 32'(pulse_log[0]), 32'h0680);
    chk("gap latency", pulse_cyc[0] - tl, 4);

    // Reset mid-vector discards the partial vector.
    pulse_log.delete(); pulse_cyc.delete();
    step(1'b1, 16'h0200);
    step(1'b1, 16'h0200);
    rst_n = 1'b0;
    step(1'b0, 16'h0000);
    rst_n = 1'b1;
    idle(1);
    send_run(3, 16'h0200, tl);
    drain();
    chk("rst count", pulse_log.size(), 1);
    chk("rst value", 32'(pulse_log[0]), 32'h0680);

    // Address wrap over three vectors.
    pulse_log.delete(); pulse_cyc.delete();
    send_run(9, 16'h0200, tl);
    drain();
    chk("wrap pulses", pulse_log.size(), 3);

    // Randomized batches: full range, small values, extremes, full range.
    for (int b = 0; b < 4; b++) begin
      for (int a = 0; a < NW; a++) mem[a] = rnd16(b);
      bias = rnd16(b);
      for (int v = 0; v < 20; v++) begin
        for (int i = 0; i < NW; i++) begin
          step(1'b1, rnd16(b));
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
      end
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
